// File: rtl/regfile_scan_reader.sv
// Steps through a register file one entry per button press or auto-scan tick,
// holding the most recent captured value and its address for display.
module regfile_scan_reader #(
    parameter int NUM_REGS    = 16,
    parameter int READ_LAT    = 1,
    parameter int AUTO_PERIOD = 50_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_step_n,
    input  logic        btn_auto_n,
    output logic [3:0]  rd_addr,
    input  logic [15:0] rd_data,
    output logic [15:0] disp_value,
    output logic [3:0]  disp_addr,
    output logic        disp_valid,
    output logic        busy,
    output logic        auto_en
);

    localparam int TW = $clog2(AUTO_PERIOD);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t        state_q, state_d;
    logic [2:0]    step_sync_q, step_sync_d;
    logic [2:0]    auto_sync_q, auto_sync_d;
    logic [3:0]    ptr_q, ptr_d;
    logic [3:0]    rd_addr_q, rd_addr_d;
    logic [1:0]    wait_q, wait_d;
    logic [15:0]   disp_value_q, disp_value_d;
    logic [3:0]    disp_addr_q, disp_addr_d;
    logic          disp_valid_q, disp_valid_d;
    logic          auto_en_q, auto_en_d;
    logic [TW-1:0] tick_q, tick_d;

    logic step_ev;
    logic auto_ev;
    logic auto_tick;

    // Bit 0/1 are the synchronizer pair, bit 2 is the history flop; a press is
    // the history still high while the synchronized level has dropped.
    assign step_ev   = step_sync_q[2] & ~step_sync_q[1];
    assign auto_ev   = auto_sync_q[2] & ~auto_sync_q[1];
    assign auto_tick = auto_en_q && (tick_q == TW'(AUTO_PERIOD - 1));

    always_comb begin
        step_sync_d  = {step_sync_q[1:0], btn_step_n};
        auto_sync_d  = {auto_sync_q[1:0], btn_auto_n};
        state_d      = state_q;
        ptr_d        = ptr_q;
        rd_addr_d    = rd_addr_q;
        wait_d       = wait_q;
        disp_value_d = disp_value_q;
        disp_addr_d  = disp_addr_q;
        disp_valid_d = disp_valid_q;
        auto_en_d    = auto_en_q ^ auto_ev;

        if (!auto_en_q || auto_tick) begin
            tick_d = '0;
        end else begin
            tick_d = tick_q + TW'(1);
        end

        // Requests arriving outside IDLE are simply ignored.
        case (state_q)
            IDLE: begin
                if (step_ev || auto_tick) begin
                    state_d   = ISSUE;
                    rd_addr_d = ptr_q;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                wait_d  = '0;
            end
            WAIT: begin
                if (wait_q == 2'(READ_LAT - 1)) begin
                    state_d      = IDLE;
                    disp_value_d = rd_data;
                    disp_addr_d  = rd_addr_q;
                    disp_valid_d = 1'b1;
                    ptr_d        = (ptr_q == 4'(NUM_REGS - 1)) ? 4'd0 : ptr_q + 4'd1;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            step_sync_q  <= 3'b111;
            auto_sync_q  <= 3'b111;
            ptr_q        <= '0;
            rd_addr_q    <= '0;
            wait_q       <= '0;
            disp_value_q <= '0;
            disp_addr_q  <= '0;
            disp_valid_q <= 1'b0;
            auto_en_q    <= 1'b0;
            tick_q       <= '0;
        end else begin
            state_q      <= state_d;
            step_sync_q  <= step_sync_d;
            auto_sync_q  <= auto_sync_d;
            ptr_q        <= ptr_d;
            rd_addr_q    <= rd_addr_d;
            wait_q       <= wait_d;
            disp_value_q <= disp_value_d;
            disp_addr_q  <= disp_addr_d;
            disp_valid_q <= disp_valid_d;
            auto_en_q    <= auto_en_d;
            tick_q       <= tick_d;
        end
    end

    assign rd_addr    = rd_addr_q;
    assign disp_value = disp_value_q;
    assign disp_addr  = disp_addr_q;
    assign disp_valid = disp_valid_q;
    assign auto_en    = auto_en_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_regfile_scan_reader.sv
// Randomized scoreboard bench for regfile_scan_reader against an edge-level
// behavioural model of button events, auto ticks and read occupancy.
module tb_regfile_scan_reader;

    localparam int NUM_REGS    = 16;
    localparam int READ_LAT    = 1;
    localparam int AUTO_PERIOD = 8;

    typedef struct {
        int          cyc;
        logic [3:0]  addr;
        logic [15:0] val;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        btn_step_n;
    logic        btn_auto_n;
    logic [3:0]  rd_addr;
    logic [15:0] rd_data;
    logic [15:0] disp_value;
    logic [3:0]  disp_addr;
    logic        disp_valid;
    logic        busy;
    logic        auto_en;

    logic [15:0] mem [NUM_REGS];

    int   cyc        = 0;
    int   busy_until = -100;
    int   mptr       = 0;
    bit   m_auto_on  = 0;
    int   auto_start = 0;
    bit   mon_en     = 0;
    bit   step_at [int];
    bit   auto_at [int];
    exp_t sb [$];
    int   n_checks   = 0;
    int   n_pass     = 0;

    regfile_scan_reader #(
        .NUM_REGS   (NUM_REGS),
        .READ_LAT   (READ_LAT),
        .AUTO_PERIOD(AUTO_PERIOD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_step_n(btn_step_n),
        .btn_auto_n(btn_auto_n),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .disp_value(disp_value),
        .disp_addr (disp_addr),
        .disp_valid(disp_valid),
        .busy      (busy),
        .auto_en   (auto_en)
    );

    always #5 clk = ~clk;

    // Register file with one cycle of read latency.
    always @(posedge clk) rd_data <= mem[rd_addr];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            $display("[TB] FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end else begin
            n_pass++;
        end
    endtask

    // Called just after a falling edge; a 1->0 level change here becomes an
    // event that the reader acts on three rising edges later.
    task automatic applyStimulus(input logic s, input logic a);
        if (btn_step_n === 1'b1 && s === 1'b0) step_at[cyc + 3] = 1'b1;
        if (btn_auto_n === 1'b1 && a === 1'b0) auto_at[cyc + 3] = 1'b1;
        btn_step_n = s;
        btn_auto_n = a;
    endtask

    task automatic resetPulse();
        @(negedge clk);
        #2;
        reset      = 1'b1;
        btn_step_n = 1'b1;
        btn_auto_n = 1'b1;
        #1;
        checkOutput("rst_rd_addr", rd_addr, 0);
        checkOutput("rst_disp_value", disp_value, 0);
        checkOutput("rst_disp_addr", disp_addr, 0);
        checkOutput("rst_disp_valid", disp_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_auto_en", auto_en, 0);
        mptr       = 0;
        busy_until = -100;
        m_auto_on  = 0;
        step_at.delete();
        auto_at.delete();
        sb.delete();
        repeat (2) @(negedge clk);
        #2;
        reset  = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic pressStep(input int hold, input int gap);
        @(negedge clk);
        applyStimulus(1'b0, btn_auto_n);
        repeat (hold) @(negedge clk);
        applyStimulus(1'b1, btn_auto_n);
        repeat (gap) @(negedge clk);
    endtask

    task automatic pressAuto(input int hold, input int gap);
        @(negedge clk);
        applyStimulus(btn_step_n, 1'b0);
        repeat (hold) @(negedge clk);
        applyStimulus(btn_step_n, 1'b1);
        repeat (gap) @(negedge clk);
    endtask

    // Reference model: a read is requested by a step event or an auto tick,
    // is accepted only if the previous read has finished, and captures
    // 1 + READ_LAT edges after acceptance.
    initial begin
        bit req;
        forever begin
            @(posedge clk);
            cyc++;
            if (!reset) begin
                req = step_at.exists(cyc);
                if (m_auto_on && cyc > auto_start && ((cyc - auto_start) % AUTO_PERIOD) == 0)
                    req = 1'b1;
                if (auto_at.exists(cyc)) begin
                    m_auto_on  = !m_auto_on;
                    auto_start = cyc;
                end
                if (req && cyc > busy_until) begin
                    busy_until = cyc + 1 + READ_LAT;
                    sb.push_back('{cyc: busy_until, addr: 4'(mptr), val: mem[mptr]});
                    mptr = (mptr + 1) % NUM_REGS;
                end
            end
        end
    end

    // Monitor: any change of the display triple is a capture to be scored.
    initial begin
        logic [20:0] prev;
        logic [20:0] cur;
        exp_t        e;
        int          left;
        forever begin
            @(negedge clk);
            cur = {disp_valid, disp_addr, disp_value};
            if (reset || !mon_en) begin
                prev = cur;
            end else begin
                left = busy_until - cyc;
                checkOutput("busy", busy, (left >= 1 && left <= 1 + READ_LAT) ? 1 : 0);
                checkOutput("auto_en", auto_en, m_auto_on ? 1 : 0);
                if (cur !== prev) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        $display("[TB] FAIL unexpected_capture actual addr=%0d value=%h required none (cycle %0d)",
                                 disp_addr, disp_value, cyc);
                    end else begin
                        e = sb.pop_front();
                        checkOutput("cap_cycle", cyc, e.cyc);
                        checkOutput("cap_addr", disp_addr, e.addr);
                        checkOutput("cap_value", disp_value, e.val);
                        checkOutput("cap_valid", disp_valid, 1);
                    end
                    prev = cur;
                end
            end
        end
    end

    initial begin
        logic s;
        logic a;
        clk        = 1'b0;
        reset      = 1'b1;
        btn_step_n = 1'b1;
        btn_auto_n = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) mem[i] = 16'h1000 + 16'(i);

        resetPulse();
        repeat (20) begin
            @(negedge clk);
            checkOutput("idle_busy", busy, 0);
            checkOutput("idle_valid", disp_valid, 0);
            checkOutput("idle_rd_addr", rd_addr, 0);
        end

        $display("[TB] single step press");
        pressStep(3, 10);

        $display("[TB] 17 presses with wrap");
        resetPulse();
        repeat (17) pressStep(3, 7);
        checkOutput("wrap_last_addr", disp_addr, 0);
        checkOutput("wrap_last_value", disp_value, 16'h1000);

        $display("[TB] second fall while busy");
        @(negedge clk);
        applyStimulus(1'b0, 1'b1);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1);
        repeat (3) @(negedge clk);
        applyStimulus(1'b1, 1'b1);
        repeat (10) @(negedge clk);
        checkOutput("bounce_addr", disp_addr, 1);
        pressStep(3, 10);
        checkOutput("after_bounce_addr", disp_addr, 2);

        $display("[TB] auto scan");
        resetPulse();
        pressAuto(3, 40);
        checkOutput("auto_on", auto_en, 1);
        pressAuto(3, 30);
        checkOutput("auto_off", auto_en, 0);

        $display("[TB] reset during WAIT");
        @(negedge clk);
        applyStimulus(1'b0, 1'b1);
        repeat (3) @(negedge clk);
        checkOutput("pre_reset_busy", busy, 1);
        resetPulse();
        repeat (15) @(negedge clk);
        checkOutput("post_reset_valid", disp_valid, 0);
        pressStep(3, 10);
        checkOutput("post_reset_addr", disp_addr, 0);

        $display("[TB] random phase");
        for (int i = 0; i < NUM_REGS; i++) mem[i] = 16'($urandom);
        s = 1'b1;
        a = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 5) == 0) s = ~s;
            if ($urandom_range(0, 59) == 0) a = ~a;
            applyStimulus(s, a);
        end
        @(negedge clk);
        applyStimulus(1'b1, 1'b1);
        repeat (6) @(negedge clk);
        if (m_auto_on) pressAuto(3, 6);
        repeat (30) @(negedge clk);
        checkOutput("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_scan_reader.md
REGFILE_SCAN_READER -- requirements
Module: regfile_scan_reader

Interface
REQ-001 Parameter NUM_REGS, default 16: number of register-file entries scanned; address width is 4 bits.
REQ-002 Parameter READ_LAT, default 1: cycles from a stable rd_addr to valid rd_data (range 1..3).
REQ-003 Parameter AUTO_PERIOD, default 50_000_000: clk cycles between auto-scan ticks (minimum 8).
REQ-004 clk  input  1  single system clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high; takes effect immediately, with no clock edge required.
REQ-006 btn_step_n  input  1  raw active-low step button, asynchronous to clk.
REQ-007 btn_auto_n  input  1  raw active-low auto-mode toggle button, asynchronous to clk.
REQ-008 rd_addr  output  4  registered read address to the register-file read port.
REQ-009 rd_data  input  16  register-file read data, valid READ_LAT cycles after rd_addr is stable.
REQ-010 disp_value  output  16  last captured register value.
REQ-011 disp_addr  output  4  address of the value held in disp_value.
REQ-012 disp_valid  output  1  high once any capture has completed since reset.
REQ-013 busy  output  1  high whenever the FSM is not IDLE (combinational from state).
REQ-014 auto_en  output  1  current auto-scan mode.

Function
REQ-015 Each button SHALL pass through two synchronizer flops and then a third history flop.
REQ-016 An event (step_ev or auto_ev) SHALL be asserted for exactly one cycle when the history flop is 1 and the second synchronizer flop is 0 (a falling edge).
REQ-017 A raw button fall set up before edge k SHALL produce an event during the cycle following edge k+1.
REQ-018 The FSM SHALL have three states: IDLE, ISSUE and WAIT.
REQ-019 IDLE -> ISSUE on (step_ev or auto_tick); on that edge rd_addr <= ptr.
REQ-020 ISSUE -> WAIT unconditionally; on that edge the wait counter is cleared.
REQ-021 WAIT SHALL remain for READ_LAT cycles, then return to IDLE; on that exit edge: disp_value <= rd_data, disp_addr <= rd_addr, disp_valid <= 1, ptr <= ptr+1.
REQ-022 Capture latency: with READ_LAT=1, a step_ev seen at edge k+2 leaves IDLE at k+2 and updates disp_value at edge k+4.
REQ-023 ptr SHALL wrap from NUM_REGS-1 to 0 with no gap or repeat.
REQ-024 step_ev or auto_tick occurring while busy SHALL be dropped; it is neither queued nor counted.
REQ-025 Simultaneous step_ev and auto_tick in IDLE SHALL cause exactly one read.
REQ-026 rd_addr SHALL hold its last value while in IDLE.
REQ-027 auto_ev SHALL toggle auto_en, whether or not busy.
REQ-028 While auto_en=1, the tick counter SHALL count 0..AUTO_PERIOD-1, with auto_tick high for one cycle at terminal count, and wrap.
REQ-029 The tick counter SHALL keep counting while busy.
REQ-030 While auto_en=0, the tick counter SHALL be held at 0 and auto_tick SHALL be 0.
REQ-031 The step button SHALL remain functional while auto_en=1.

Reset
REQ-032 reset SHALL force state=IDLE, ptr=0, rd_addr=0, disp_value=0, disp_addr=0, disp_valid=0, auto_en=0, and tick counter=0.
REQ-033 reset SHALL force all synchronizer and history flops to 1, so held-high buttons produce no spurious event after release.
REQ-034 reset asserted in ISSUE or WAIT SHALL abort the read with no capture; after release the next capture is from address 0.

Verification
REQ-035 Reset, then buttons high for 20 cycles -> busy=0, disp_valid=0, rd_addr=0 throughout.
REQ-036 Register-file model R[i]=0x1000+i, READ_LAT=1, one step press -> at edge k+4: disp_value=0x1000, disp_addr=0, disp_valid=1; busy high for exactly 2 cycles.
REQ-037 17 step presses spaced 10 cycles apart -> the 16th capture gives disp_addr=15/0x100F, the 17th gives disp_addr=0/0x1000.
REQ-038 A second button fall 1 cycle after the first (while busy) -> exactly one capture; ptr advances by 1.
REQ-039 AUTO_PERIOD=8, press auto -> auto_en=1 and a capture every 8 cycles with addresses 0,1,2,...; press auto again -> auto_en=0 and no further captures.
REQ-040 reset pulsed while in WAIT -> all outputs 0 in the same cycle; after release no capture occurs until the next press, which reads address 0.
